// File: rtl/pong_match_ctrl_if.sv
// Player/physics/render signal bundle for the pong match sequencer.
// master drives the buttons and out-of-bounds events. slave is the sequencer.
interface pong_match_ctrl_if #(
  parameter int SCORE_W = 4
);
  logic               frame_tick;
  logic               start;
  logic               pause;
  logic               out_left;
  logic               out_right;
  logic               ball_rst_n;
  logic               go;
  logic               dir_right;
  logic               freeze;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic               game_over;
  logic               winner;
  logic [2:0]         state;

  modport master (
    output frame_tick, start, pause, out_left, out_right,
    input  ball_rst_n, go, dir_right, freeze, score_l, score_r,
           game_over, winner, state
  );

  modport slave (
    input  frame_tick, start, pause, out_left, out_right,
    output ball_rst_n, go, dir_right, freeze, score_l, score_r,
           game_over, winner, state
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve delay in frames, one-cycle launch, scoring, pause and win detection.
// All outputs are registered and decoded from the next state, so they line up with state.
module pong_match_ctrl #(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 60,
  parameter int SCORE_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  pong_match_ctrl_if.slave mif
);

  localparam int CNT_W = (SERVE_DELAY > 0) ? $clog2(SERVE_DELAY + 1) : 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    LAUNCH     = 3'd2,
    PLAY       = 3'd3,
    POINT      = 3'd4,
    PAUSED     = 3'd5,
    OVER       = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic               dir_q, dir_d;
  logic               winner_q, winner_d;
  logic               scorer_r_q, scorer_r_d;
  logic               start_q;
  logic               ball_rst_n_q, go_q, freeze_q, game_over_q;
  logic               start_edge;

  assign start_edge = mif.start & ~start_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    dir_d      = dir_q;
    winner_d   = winner_q;
    scorer_r_d = scorer_r_q;
    case (state_q)
      IDLE, OVER: begin
        if (start_edge) begin
          state_d   = SERVE_WAIT;
          score_l_d = '0;
          score_r_d = '0;
          dir_d     = 1'b0;
          winner_d  = 1'b0;
          cnt_d     = CNT_W'(SERVE_DELAY);
        end
      end
      SERVE_WAIT: begin
        if (cnt_q == '0) begin
          state_d = LAUNCH;
        end else if (mif.frame_tick && !mif.pause) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LAUNCH: state_d = PLAY;
      PLAY: begin
        if (mif.pause) begin
          state_d = PAUSED;
        end else if (mif.out_left && !mif.out_right) begin
          state_d    = POINT;
          score_r_d  = score_r_q + SCORE_W'(1);
          scorer_r_d = 1'b1;
        end else if (mif.out_right && !mif.out_left) begin
          state_d    = POINT;
          score_l_d  = score_l_q + SCORE_W'(1);
          scorer_r_d = 1'b0;
        end else if (mif.out_left && mif.out_right) begin
          // Ambiguous double exit: replay the rally without awarding a point.
          state_d = SERVE_WAIT;
          cnt_d   = CNT_W'(SERVE_DELAY);
        end
      end
      PAUSED: begin
        if (!mif.pause) state_d = PLAY;
      end
      POINT: begin
        if ((scorer_r_q ? score_r_q : score_l_q) == SCORE_W'(WIN_SCORE)) begin
          state_d  = OVER;
          winner_d = scorer_r_q;
        end else begin
          state_d = SERVE_WAIT;
          cnt_d   = CNT_W'(SERVE_DELAY);
          dir_d   = ~scorer_r_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      dir_q        <= 1'b0;
      winner_q     <= 1'b0;
      scorer_r_q   <= 1'b0;
      start_q      <= 1'b1;
      ball_rst_n_q <= 1'b0;
      go_q         <= 1'b0;
      freeze_q     <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      dir_q        <= dir_d;
      winner_q     <= winner_d;
      scorer_r_q   <= scorer_r_d;
      start_q      <= mif.start;
      ball_rst_n_q <= (state_d == LAUNCH) || (state_d == PLAY) || (state_d == PAUSED);
      go_q         <= (state_d == LAUNCH);
      freeze_q     <= (state_d == PAUSED);
      game_over_q  <= (state_d == OVER);
    end
  end

  assign mif.ball_rst_n = ball_rst_n_q;
  assign mif.go         = go_q;
  assign mif.dir_right  = dir_q;
  assign mif.freeze     = freeze_q;
  assign mif.score_l    = score_l_q;
  assign mif.score_r    = score_r_q;
  assign mif.game_over  = game_over_q;
  assign mif.winner     = winner_q;
  assign mif.state      = state_q;

endmodule
